// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory endpoint for the core's data port.
// Accepts one load/store at a time, waits LATENCY cycles, then answers with a
// one-cycle resp_valid pulse carrying rdata/err. Stores are byte-masked.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [30:0] DEPTH_W = 31'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH];

  // With zero wait states the request is serviced on the accepting edge, so
  // the live inputs are used in IDLE and the captured copy everywhere else.
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic [29:0] widx;
  logic [AW-1:0] midx;
  logic        addr_err;
  logic        accept;
  logic        commit;

  assign sel_we    = (state_q == IDLE) ? we    : we_q;
  assign sel_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign sel_wdata = (state_q == IDLE) ? wdata : wdata_q;
  assign sel_be    = (state_q == IDLE) ? be    : be_q;
  assign widx      = sel_addr[31:2];
  assign midx      = widx[AW-1:0];
  assign addr_err  = (sel_addr[1:0] != 2'b00) || ({1'b0, widx} >= DEPTH_W);

  // ready_q keeps a zero-latency build from committing a store on an edge
  // where reset is still held (state cannot advance then, but memory could).
  assign accept = (state_q == IDLE) && req && ((LATENCY != 0) || ready_q);
  assign commit = ((LATENCY == 0) && accept) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign rdata      = rdata_q;
  assign err        = err_q;

  // Next-state, wait counter and response data decided at the commit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = addr_err;
      rdata_d = (addr_err || sel_we) ? 32'd0 : mem[midx];
    end
  end

  // Control state and response outputs; reset clears them asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
    end
  end

  // Request fields captured on acceptance and held stable while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Byte-masked store at the edge entering RESP; the array is never cleared.
  always_ff @(posedge clk) begin
    if (commit && sel_we && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[midx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for the main
// traffic and a LATENCY=0 instance for the back-to-back streaming case.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_a, we_a;
  logic [31:0] addr_a, wdata_a;
  logic [3:0]  be_a;
  logic        busy_a, rv_a, err_a;
  logic [31:0] rdata_a;

  logic        req_b, we_b;
  logic [31:0] addr_b, wdata_b;
  logic [3:0]  be_b;
  logic        busy_b, rv_b, err_b;
  logic [31:0] rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
    .clk(clk), .reset(rst), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .be(be_a), .busy(busy_a), .resp_valid(rv_a),
    .rdata(rdata_a), .err(err_a)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut_b (
    .clk(clk), .reset(rst), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .be(be_b), .busy(busy_b), .resp_valid(rv_b),
    .rdata(rdata_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on instance A; lat counts edges from the accepting edge
  // up to and including the edge that raises resp_valid.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, output logic [31:0] rd, output logic e,
                      output int lat);
    @(negedge clk);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = wd; be_a = b;
    @(posedge clk);
    #1 req_a = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rv_a && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = rdata_a;
    e  = err_a;
    check_eq("busy_in_resp", 32'(busy_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq("rv_one_cycle", 32'(rv_a), 32'd0);
    check_eq("busy_after_resp", 32'(busy_a), 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          pulses;

  initial begin
    rst = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_rv", 32'(rv_a), 32'd0);
    check_eq("rst_rdata", rdata_a, 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full store then load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check_eq("st_lat", 32'(lat), 32'd3);
    check_eq("st_err", 32'(e), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check_eq("ld_lat", 32'(lat), 32'd3);
    check_eq("ld_rdata", rd, 32'hDEADBEEF);
    check_eq("ld_err", 32'(e), 32'd0);

    // Partial store
    xact(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e, lat);
    check_eq("pst_err", 32'(e), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check_eq("pst_rdata", rd, 32'hDE22BE44);

    // Error cases
    xact(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
    check_eq("mis_err", 32'(e), 32'd1);
    check_eq("mis_rdata", rd, 32'd0);
    check_eq("err_held", 32'(err_a), 32'd1);
    xact(1'b0, 32'h400, 32'h0, 4'h0, rd, e, lat);
    check_eq("oob_err", 32'(e), 32'd1);
    check_eq("oob_rdata", rd, 32'd0);
    xact(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    check_eq("mis_st_err", 32'(e), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check_eq("after_err_rdata", rd, 32'hDE22BE44);
    check_eq("after_err_err", 32'(e), 32'd0);

    // Store with no byte enables
    xact(1'b1, 32'h10, 32'h55555555, 4'h0, rd, e, lat);
    check_eq("be0_err", 32'(e), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check_eq("be0_rdata", rd, 32'hDE22BE44);

    // Zero-latency instance: req held high streams a response every 2 cycles
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b1; addr_b = 32'h8; wdata_b = 32'hCAFEF00D; be_b = 4'hF;
    @(posedge clk);
    #1 req_b = 1'b0;
    @(negedge clk);
    check_eq("b_st_rv", 32'(rv_b), 32'd1);
    check_eq("b_st_err", 32'(err_b), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h8;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("b_rv", 32'(rv_b), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("b_busy", 32'(busy_b), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (rv_b) begin
        pulses++;
        check_eq("b_rdata", rdata_b, 32'hCAFEF00D);
      end
      if (i == 6) req_b = 1'b0;
    end
    check_eq("b_pulses", 32'(pulses), 32'd4);

    // req activity while busy is ignored; captured fields stay in use
    xact(1'b1, 32'h34, 32'h0BADF00D, 4'hF, rd, e, lat);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h30; wdata_a = 32'hA5A5A5A5; be_a = 4'hF;
    @(posedge clk);
    #1 addr_a = 32'h34; wdata_a = 32'hFFFFFFFF; be_a = 4'h3;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rv_a) pulses++;
      if (i == 3) req_a = 1'b0;
      @(posedge clk);
    end
    check_eq("busy_req_pulses", 32'(pulses), 32'd1);
    xact(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
    check_eq("busy_req_rdata30", rd, 32'hA5A5A5A5);
    xact(1'b0, 32'h34, 32'h0, 4'h0, rd, e, lat);
    check_eq("busy_req_rdata34", rd, 32'h0BADF00D);

    // Reset during WAIT aborts the store
    xact(1'b1, 32'h20, 32'h12345678, 4'hF, rd, e, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    check_eq("pre_rst_rdata", rd, 32'h12345678);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h0000CAFE; be_a = 4'hF;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    check_eq("wait_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy_a), 32'd0);
    check_eq("arst_rv", 32'(rv_a), 32'd0);
    check_eq("arst_rdata", rdata_a, 32'd0);
    check_eq("arst_err", 32'(err_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    check_eq("post_rst_rdata", rd, 32'h12345678);
    check_eq("post_rst_lat", 32'(lat), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
